// File: rtl/alu_pkg.sv
// Shared opcode encodings, FSM state encoding and result-width helper for alu_seq_accum.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_CAT = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_ACC = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_CLR = 3'b111;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_MULT = 1'b1;

  function automatic int res_width(input int n);
    return 2 * n;
  endfunction

endpackage

// File: rtl/shift_add_mult.sv
// Sequential shift-add multiplier: load on start, one partial-product step per asserted
// step, last flags the N-th step while product presents the completed result.
module shift_add_mult
  import alu_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    step,
  input  logic [N-1:0]            a,
  input  logic [N-1:0]            b,
  output logic                    last,
  output logic [res_width(N)-1:0] product
);

  localparam int RW = res_width(N);
  localparam int CW = $clog2(N) + 1;

  logic [RW-1:0] mcand;
  logic [N-1:0]  mplier;
  logic [RW-1:0] acc;
  logic [CW-1:0] cnt;

  // product is the partial sum after the current step, so the final step can be
  // written straight into the result register on the same edge.
  always_comb begin
    product = acc + (mplier[0] ? mcand : '0);
    last    = step && (cnt == CW'(N - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (start) begin
      mcand  <= RW'(a);
      mplier <= b;
      acc    <= '0;
      cnt    <= '0;
    end else if (step) begin
      acc    <= product;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/alu_seq_accum.sv
// Registered N-bit ALU with accumulator feedback and an N-cycle multiply; Start is ignored while Busy.
// Define ALU_SAT_EN to make accumulate (101) and shift-left (110) saturate instead of wrapping.
module alu_seq_accum
  import alu_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                    Clock,
  input  logic                    Reset_b,
  input  logic [N-1:0]            A,
  input  logic [N-1:0]            B,
  input  logic [2:0]              Function,
  input  logic                    Start,
  output logic                    Busy,
  output logic                    Done,
  output logic [res_width(N)-1:0] ALUout
);

  localparam int RW = res_width(N);

  logic [0:0]    state;
  logic [RW-1:0] alu_out;
  logic          done_q;
  logic          accept;
  logic          mult_start;
  logic          mult_step;
  logic          mult_last;
  logic [RW-1:0] mult_product;
  logic [RW-1:0] single_res;

`ifdef ALU_SAT_EN
  logic [RW:0]     acc_sum;
  logic [2*RW-1:0] shl_wide;
  logic            shl_big;
`else
  logic [RW-1:0]   acc_sum;
`endif

  assign accept     = Start && (state == ST_IDLE);
  assign mult_start = accept && (Function == OP_MUL);
  assign mult_step  = (state == ST_MULT);

  shift_add_mult #(.N(N)) u_mult (
    .clk     (Clock),
    .rst_n   (Reset_b),
    .start   (mult_start),
    .step    (mult_step),
    .a       (A),
    .b       (B),
    .last    (mult_last),
    .product (mult_product)
  );

  always_comb begin
    single_res = '0;
`ifdef ALU_SAT_EN
    acc_sum  = {1'b0, alu_out} + (RW + 1)'(A);
    shl_wide = (2 * RW)'(alu_out) << B;
    shl_big  = int'(B) >= RW;
`else
    acc_sum  = alu_out + RW'(A);
`endif
    case (Function)
      OP_ADD: single_res = RW'(A) + RW'(B);
      OP_OR:  single_res = RW'(|{A, B});
      OP_AND: single_res = RW'(&{A, B});
      OP_CAT: single_res = {A, B};
`ifdef ALU_SAT_EN
      OP_ACC: single_res = acc_sum[RW] ? '1 : acc_sum[RW-1:0];
      // Any set bit pushed past the top (or a shift past the width) pins to all ones.
      OP_SHL: begin
        if (shl_big)
          single_res = (|alu_out) ? '1 : '0;
        else
          single_res = (|shl_wide[2*RW-1:RW]) ? '1 : shl_wide[RW-1:0];
      end
`else
      OP_ACC: single_res = acc_sum;
      OP_SHL: single_res = alu_out << B;
`endif
      default: single_res = '0;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_b) begin
    if (!Reset_b) begin
      state   <= ST_IDLE;
      alu_out <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state == ST_IDLE) begin
        if (mult_start) begin
          state <= ST_MULT;
        end else if (accept) begin
          alu_out <= single_res;
          done_q  <= 1'b1;
        end
      end else if (mult_last) begin
        alu_out <= mult_product;
        done_q  <= 1'b1;
        state   <= ST_IDLE;
      end
    end
  end

  assign Busy   = (state == ST_MULT);
  assign Done   = done_q;
  assign ALUout = alu_out;

endmodule

// File: tb/tb_alu_seq_accum.sv
// Directed plus randomized checks of alu_seq_accum (N=4) against an arithmetic reference model.
module tb_alu_seq_accum;

  logic       Clock = 1'b0;
  logic       Reset_b;
  logic       Start;
  logic [3:0] A;
  logic [3:0] B;
  logic [2:0] Function;
  logic       Busy;
  logic       Done;
  logic [7:0] ALUout;

  int vectors     = 0;
  int miscompares = 0;
  int exp_acc     = 0;

  alu_seq_accum #(.N(4)) dut (
    .Clock    (Clock),
    .Reset_b  (Reset_b),
    .A        (A),
    .B        (B),
    .Function (Function),
    .Start    (Start),
    .Busy     (Busy),
    .Done     (Done),
    .ALUout   (ALUout)
  );

  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    vectors++;
    assert (obs === expv)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference result computed from the opcode definitions with plain integer arithmetic.
  function automatic int model(input int op, input int a, input int b, input int acc);
    longint v;
    case (op)
      0: return a + b;
      1: return (a != 0 || b != 0) ? 1 : 0;
      2: return (a == 15 && b == 15) ? 1 : 0;
      3: return a * 16 + b;
      4: return a * b;
      5: begin
        v = acc + a;
`ifdef ALU_SAT_EN
        return (v > 255) ? 255 : int'(v);
`else
        return int'(v % 256);
`endif
      end
      6: begin
        v = longint'(acc) * (longint'(1) << b);
`ifdef ALU_SAT_EN
        return (v > 255) ? 255 : int'(v);
`else
        return int'(v % 256);
`endif
      end
      default: return 0;
    endcase
  endfunction

  task automatic run_op(input int op, input int a, input int b, input string tag);
    Start = 1'b1; Function = 3'(op); A = 4'(a); B = 4'(b);
    tick();
    if (op == 4) begin
      // Keep hammering Start with junk requests; none of them may be taken.
      for (int i = 0; i < 4; i++) begin
        check({tag, "_busy"}, 16'(Busy), 16'd1);
        check({tag, "_nodone"}, 16'(Done), 16'd0);
        check({tag, "_hold"}, 16'(ALUout), 16'(exp_acc));
        Start = 1'b1;
        Function = 3'($urandom_range(7));
        A = 4'($urandom_range(15));
        B = 4'($urandom_range(15));
        tick();
      end
    end
    Start = 1'b0;
    exp_acc = model(op, a, b, exp_acc);
    check({tag, "_out"}, 16'(ALUout), 16'(exp_acc));
    check({tag, "_done"}, 16'(Done), 16'd1);
    check({tag, "_idle"}, 16'(Busy), 16'd0);
  endtask

  task automatic idle_cycle(input string tag);
    Start = 1'b0;
    tick();
    check({tag, "_done_low"}, 16'(Done), 16'd0);
    check({tag, "_stable"}, 16'(ALUout), 16'(exp_acc));
  endtask

  initial begin
    Reset_b = 1'b0; Start = 1'b0; A = '0; B = '0; Function = '0;
    #1;
    check("reset_out", 16'(ALUout), 16'd0);
    check("reset_busy", 16'(Busy), 16'd0);
    check("reset_done", 16'(Done), 16'd0);
    tick(); tick();
    Reset_b = 1'b1;
    tick();

    // Reset in the middle of a multiply
    run_op(3, 10, 5, "cat_a5");
    check("cat_a5_const", 16'(ALUout), 16'hA5);
    Start = 1'b1; Function = 3'd4; A = 4'hF; B = 4'hF;
    tick();
    Start = 1'b0;
    check("rst_mult_busy", 16'(Busy), 16'd1);
    tick();
    Reset_b = 1'b0;
    #1;
    exp_acc = 0;
    check("rst_mid_out", 16'(ALUout), 16'd0);
    check("rst_mid_busy", 16'(Busy), 16'd0);
    check("rst_mid_done", 16'(Done), 16'd0);
    tick();
    Reset_b = 1'b1;
    tick();
    run_op(0, 1, 1, "post_rst_add");
    check("post_rst_add_const", 16'(ALUout), 16'h02);
    idle_cycle("post_rst");

    // Single-cycle ops
    run_op(0, 15, 1, "add_f1");   idle_cycle("add_f1");
    run_op(1, 0, 0, "or_00");     idle_cycle("or_00");
    run_op(2, 15, 15, "and_ff");  idle_cycle("and_ff");
    run_op(3, 10, 5, "cat_a5b");  idle_cycle("cat_a5b");

    // Multiply
    run_op(4, 15, 15, "mul_ff");
    check("mul_ff_const", 16'(ALUout), 16'hE1);
    idle_cycle("mul_ff");

    // Accumulate wrap / saturate
    run_op(7, 0, 0, "clr");
    run_op(3, 15, 15, "cat_ff");
    run_op(5, 2, 0, "acc_wrap");
    idle_cycle("acc_wrap");

    // Shifts
    run_op(3, 0, 3, "cat_03");
    run_op(6, 0, 4, "shl4");
    check("shl4_const", 16'(ALUout), 16'h30);
    run_op(6, 0, 4, "shl4_again");
    run_op(3, 0, 3, "cat_03b");
    run_op(6, 0, 9, "shl9");
    idle_cycle("shl9");

    // Back-to-back accumulate with Start held
    run_op(7, 0, 0, "clr_b2b");
    Start = 1'b1; Function = 3'd5; A = 4'd1; B = 4'd0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      exp_acc = model(5, 1, 0, exp_acc);
      check($sformatf("b2b_out%0d", k), 16'(ALUout), 16'(exp_acc));
      check($sformatf("b2b_done%0d", k), 16'(Done), 16'd1);
    end
    idle_cycle("b2b_end");

    // Randomized sequence
    for (int n = 0; n < 300; n++) begin
      int op, a, b;
      op = int'($urandom_range(7));
      a  = int'($urandom_range(15));
      b  = int'($urandom_range(15));
      run_op(op, a, b, $sformatf("rnd%0d_op%0d", n, op));
      if ($urandom_range(3) == 0) idle_cycle($sformatf("rnd%0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
